// File: rtl/ac97_frame_controller.sv
// AC-link controller for the AD1981B: builds the 256-bit output frame on bit_clk,
// queues register commands, and decodes codec-ready and read-back data from sdata_in.
module ac97_frame_controller #(
  parameter int CMD_DEPTH = 4,
  parameter int CMD_AW    = 2
) (
  input  logic              bit_clk,
  input  logic              reset_b,
  input  logic              enable,
  output logic              sync,
  output logic              sdata_out,
  input  logic              sdata_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic [19:0]       sample_left,
  input  logic [19:0]       sample_right,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_read,
  input  logic [6:0]        cmd_addr,
  input  logic [15:0]       cmd_data,
  output logic [CMD_AW:0]   cmd_pending,
  output logic              codec_ready,
  output logic              rd_valid,
  output logic [6:0]        rd_addr,
  output logic [15:0]       rd_data,
  output logic              frame_start
);

  // Handshakes: a transfer happens on the posedge where valid and ready are both high.
  // sample_ready is only raised in the frame-load cycle; cmd_ready whenever the queue has room.

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  localparam logic [CMD_AW:0] FULL_CNT = (CMD_AW + 1)'(CMD_DEPTH);

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [255:0]        frame_q, frame_d;
  logic                sync_q, sync_d;
  logic                sdata_q, sdata_d;
  logic                frame_start_q, frame_start_d;
  logic [23:0]         mem_q [CMD_DEPTH];
  logic [23:0]         mem_d [CMD_DEPTH];
  logic [CMD_AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CMD_AW:0]     count_q, count_d;
  logic                codec_ready_q, codec_ready_d;
  logic [1:0]          in_tag_q, in_tag_d;
  logic [6:0]          in_addr_q, in_addr_d;
  logic [15:0]         in_data_q, in_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic [6:0]          rd_addr_q, rd_addr_d;
  logic [15:0]         rd_data_q, rd_data_d;

  logic                load, stop, pop, push;
  logic [23:0]         head;
  logic                t14, t13, t12;
  logic [19:0]         slot1, slot2, slot3, slot4;
  logic [255:0]        new_frame;

  always_comb begin
    load      = enable && ((state_q == ST_IDLE) || (cnt_q == 8'd255));
    stop      = (state_q == ST_RUN) && (cnt_q == 8'd255) && !enable;
    cmd_ready = (count_q != FULL_CNT);
    push      = cmd_valid && cmd_ready;
    pop       = load && (count_q != '0);
    head      = mem_q[rd_ptr_q];

    t14       = pop;
    t13       = pop && !head[23];
    t12       = sample_valid;
    slot1     = pop ? {head[23], head[22:16], 12'h000} : 20'h0;
    slot2     = t13 ? {head[15:0], 4'h0} : 20'h0;
    slot3     = sample_valid ? sample_left  : 20'h0;
    slot4     = sample_valid ? sample_right : 20'h0;
    new_frame = {(t14 | t13 | t12), t14, t13, t12, t12, 11'h000,
                 slot1, slot2, slot3, slot4, 160'h0};
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    frame_d       = frame_q;
    sync_d        = sync_q;
    sdata_d       = sdata_q;
    frame_start_d = 1'b0;

    if (load) begin
      // Bit 255 leaves immediately; the rest shifts out MSB first.
      state_d       = ST_RUN;
      cnt_d         = 8'd0;
      frame_d       = {new_frame[254:0], 1'b0};
      sdata_d       = new_frame[255];
      sync_d        = 1'b1;
      frame_start_d = 1'b1;
    end else if (stop) begin
      state_d = ST_IDLE;
      cnt_d   = 8'd0;
      frame_d = '0;
      sync_d  = 1'b0;
      sdata_d = 1'b0;
    end else if (state_q == ST_RUN) begin
      cnt_d   = cnt_q + 8'd1;
      sdata_d = frame_q[255];
      frame_d = {frame_q[254:0], 1'b0};
      sync_d  = (cnt_d < 8'd16);
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {cmd_read, cmd_addr, cmd_data};
      wr_ptr_d        = wr_ptr_q + CMD_AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + CMD_AW'(1);
    if (push && !pop) count_d = count_q + (CMD_AW + 1)'(1);
    else if (pop && !push) count_d = count_q - (CMD_AW + 1)'(1);
  end

  // The bit sampled while cnt==k is input frame bit 255-k.
  always_comb begin
    codec_ready_d = codec_ready_q;
    in_tag_d      = in_tag_q;
    in_addr_d     = in_addr_q;
    in_data_d     = in_data_q;
    rd_valid_d    = 1'b0;
    rd_addr_d     = rd_addr_q;
    rd_data_d     = rd_data_q;
    if (state_q == ST_RUN) begin
      if (cnt_q == 8'd0) begin
        codec_ready_d = sdata_in;
        in_tag_d[1]   = sdata_in;
      end
      if (cnt_q == 8'd1) in_tag_d[0] = sdata_in;
      if (cnt_q >= 8'd17 && cnt_q <= 8'd23) in_addr_d = {in_addr_q[5:0], sdata_in};
      if (cnt_q >= 8'd36 && cnt_q <= 8'd51) in_data_d = {in_data_q[14:0], sdata_in};
      if (cnt_q == 8'd56 && in_tag_q == 2'b11) begin
        rd_valid_d = 1'b1;
        rd_addr_d  = in_addr_q;
        rd_data_d  = in_data_q;
      end
    end
  end

  always_ff @(posedge bit_clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      frame_q       <= '0;
      sync_q        <= 1'b0;
      sdata_q       <= 1'b0;
      frame_start_q <= 1'b0;
      mem_q         <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      codec_ready_q <= 1'b0;
      in_tag_q      <= '0;
      in_addr_q     <= '0;
      in_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      rd_addr_q     <= '0;
      rd_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      frame_q       <= frame_d;
      sync_q        <= sync_d;
      sdata_q       <= sdata_d;
      frame_start_q <= frame_start_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      codec_ready_q <= codec_ready_d;
      in_tag_q      <= in_tag_d;
      in_addr_q     <= in_addr_d;
      in_data_q     <= in_data_d;
      rd_valid_q    <= rd_valid_d;
      rd_addr_q     <= rd_addr_d;
      rd_data_q     <= rd_data_d;
    end
  end

  assign sync         = sync_q;
  assign sdata_out    = sdata_q;
  assign frame_start  = frame_start_q;
  assign sample_ready = load && sample_valid;
  assign cmd_pending  = count_q;
  assign codec_ready  = codec_ready_q;
  assign rd_valid     = rd_valid_q;
  assign rd_addr      = rd_addr_q;
  assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_ac97_frame_controller.sv
// Directed bench for ac97_frame_controller: captures whole output frames at negedge
// and plays a fixed codec frame into sdata_in.
module tb_ac97_frame_controller;

  logic        bit_clk;
  logic        reset_b;
  logic        enable;
  logic        sync;
  logic        sdata_out;
  logic        sdata_in;
  logic        sample_valid;
  logic        sample_ready;
  logic [19:0] sample_left;
  logic [19:0] sample_right;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_read;
  logic [6:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic [2:0]  cmd_pending;
  logic        codec_ready;
  logic        rd_valid;
  logic [6:0]  rd_addr;
  logic [15:0] rd_data;
  logic        frame_start;

  int checks   = 0;
  int failures = 0;

  logic [255:0] cap_f;
  int           sync_hi, sync_bad, sr_cnt, sr_idx, fs_cnt, rdv_cnt, rdv_idx;
  logic         cr_at1;
  logic [6:0]   rdv_addr;
  logic [15:0]  rdv_data;
  logic [255:0] codec_f;
  logic [255:0] zero_f;
  int           sh, fsn;

  ac97_frame_controller #(.CMD_DEPTH(4), .CMD_AW(2)) dut (
    .bit_clk      (bit_clk),
    .reset_b      (reset_b),
    .enable       (enable),
    .sync         (sync),
    .sdata_out    (sdata_out),
    .sdata_in     (sdata_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_read     (cmd_read),
    .cmd_addr     (cmd_addr),
    .cmd_data     (cmd_data),
    .cmd_pending  (cmd_pending),
    .codec_ready  (codec_ready),
    .rd_valid     (rd_valid),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .frame_start  (frame_start)
  );

  initial bit_clk = 1'b0;
  always #5 bit_clk = ~bit_clk;

  task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic push_cmd(input logic rd, input logic [6:0] a, input logic [15:0] d);
    cmd_valid = 1'b1;
    cmd_read  = rd;
    cmd_addr  = a;
    cmd_data  = d;
    @(negedge bit_clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_fs(input string name);
    int n;
    n = 0;
    while (frame_start !== 1'b1 && n < 600) begin
      @(negedge bit_clk);
      n++;
    end
    chk(name, 256'(frame_start), 256'(1));
  endtask

  // Called at the negedge of a frame's cnt 0; returns at the negedge of the next cnt 0.
  task automatic capture_frame(input logic [255:0] cf, input bit push_end, input logic [23:0] pc);
    sync_hi = 0; sync_bad = 0; sr_cnt = 0; sr_idx = -1; fs_cnt = 0;
    rdv_cnt = 0; rdv_idx = -1; cr_at1 = 1'b0; rdv_addr = '0; rdv_data = '0;
    for (int i = 0; i < 256; i++) begin
      cap_f[255-i] = sdata_out;
      if (sync === 1'b1) begin
        sync_hi++;
        if (i >= 16) sync_bad++;
      end else if (i < 16) sync_bad++;
      if (sample_ready === 1'b1) begin sr_cnt++; sr_idx = i; end
      if (frame_start === 1'b1) fs_cnt++;
      if (i == 1) cr_at1 = codec_ready;
      if (rd_valid === 1'b1) begin
        rdv_cnt++; rdv_idx = i; rdv_addr = rd_addr; rdv_data = rd_data;
      end
      sdata_in = cf[255-i];
      if (push_end && i == 255) begin
        cmd_valid = 1'b1;
        cmd_read  = pc[23];
        cmd_addr  = pc[22:16];
        cmd_data  = pc[15:0];
      end
      @(negedge bit_clk);
    end
    sdata_in  = 1'b0;
    cmd_valid = 1'b0;
  endtask

  task automatic chk_cmd_frame(input string name, input logic [15:0] tag,
                               input logic [19:0] s1, input logic [19:0] s2);
    chk({name, "_tag"}, 256'(cap_f[255:240]), 256'(tag));
    chk({name, "_s1"},  256'(cap_f[239:220]), 256'(s1));
    chk({name, "_s2"},  256'(cap_f[219:200]), 256'(s2));
    chk({name, "_rest"}, 256'(cap_f[199:0]), 256'(0));
  endtask

  initial begin
    zero_f       = '0;
    codec_f      = {16'hE000, 20'h7C000, 20'h4E530, 200'h0};
    reset_b      = 1'b0;
    enable       = 1'b0;
    sdata_in     = 1'b0;
    sample_valid = 1'b0;
    sample_left  = '0;
    sample_right = '0;
    cmd_valid    = 1'b0;
    cmd_read     = 1'b0;
    cmd_addr     = '0;
    cmd_data     = '0;
    repeat (3) @(negedge bit_clk);

    chk("rst_sync",   256'(sync), 256'(0));
    chk("rst_sdata",  256'(sdata_out), 256'(0));
    chk("rst_fs",     256'(frame_start), 256'(0));
    chk("rst_pend",   256'(cmd_pending), 256'(0));
    chk("rst_cready", 256'(cmd_ready), 256'(1));
    chk("rst_rd",     256'({codec_ready, rd_valid, rd_addr, rd_data}), 256'(0));

    // Idle frame: no samples, no commands.
    reset_b = 1'b1;
    enable  = 1'b1;
    wait_fs("f1_start");
    capture_frame(zero_f, 1'b0, 24'h0);
    chk("f1_frame",    cap_f, 256'(0));
    chk("f1_sync_hi",  256'(sync_hi), 256'(16));
    chk("f1_sync_bad", 256'(sync_bad), 256'(0));
    chk("f1_fs_cnt",   256'(fs_cnt), 256'(1));
    chk("f1_sr_cnt",   256'(sr_cnt), 256'(0));
    chk("f2_period",   256'(frame_start), 256'(1));

    // PCM pair held valid.
    sample_valid = 1'b1;
    sample_left  = 20'h12345;
    sample_right = 20'hFEDCB;
    capture_frame(zero_f, 1'b0, 24'h0);
    chk("f2_sr_cnt", 256'(sr_cnt), 256'(1));
    chk("f2_sr_idx", 256'(sr_idx), 256'(255));
    capture_frame(zero_f, 1'b0, 24'h0);
    chk("f3_tag",   256'(cap_f[255:240]), 256'(16'h9800));
    chk("f3_s12",   256'(cap_f[239:200]), 256'(0));
    chk("f3_left",  256'(cap_f[199:180]), 256'(20'h12345));
    chk("f3_right", 256'(cap_f[179:160]), 256'(20'hFEDCB));
    chk("f3_rest",  256'(cap_f[159:0]), 256'(0));
    chk("f3_sr_cnt", 256'(sr_cnt), 256'(1));
    sample_valid = 1'b0;

    // Single write command, with the codec returning a read-back frame.
    push_cmd(1'b0, 7'h02, 16'h0808);
    chk("wr_pend1", 256'(cmd_pending), 256'(1));
    wait_fs("f5_start");
    chk("wr_pend0", 256'(cmd_pending), 256'(0));
    capture_frame(codec_f, 1'b0, 24'h0);
    chk_cmd_frame("f5", 16'hE000, 20'h02000, 20'h08080);
    chk("f5_codec_ready", 256'(cr_at1), 256'(1));
    chk("f5_rdv_cnt",  256'(rdv_cnt), 256'(1));
    chk("f5_rdv_idx",  256'(rdv_idx), 256'(57));
    chk("f5_rd_addr",  256'(rdv_addr), 256'(7'h7C));
    chk("f5_rd_data",  256'(rdv_data), 256'(16'h4E53));

    // Five back-to-back pushes into a depth-4 queue.
    for (int j = 0; j < 5; j++) begin
      chk("fill_ready", 256'(cmd_ready), 256'(j < 4));
      push_cmd(j == 1, 7'(8'h10 + 8'(j)), 16'(32'h1111 * (j + 1)));
    end
    chk("fill_pend",  256'(cmd_pending), 256'(4));
    chk("fill_ready_full", 256'(cmd_ready), 256'(0));
    wait_fs("f7_start");
    chk("f7_pend", 256'(cmd_pending), 256'(3));
    capture_frame(zero_f, 1'b1, {1'b0, 7'h15, 16'h5555});
    chk_cmd_frame("f7", 16'hE000, 20'h10000, 20'h11110);
    chk("pushpop_pend", 256'(cmd_pending), 256'(3));
    capture_frame(zero_f, 1'b0, 24'h0);
    chk_cmd_frame("f8", 16'hC000, 20'h91000, 20'h00000);
    capture_frame(zero_f, 1'b0, 24'h0);
    chk_cmd_frame("f9", 16'hE000, 20'h12000, 20'h33330);
    capture_frame(zero_f, 1'b0, 24'h0);
    chk_cmd_frame("f10", 16'hE000, 20'h13000, 20'h44440);
    capture_frame(zero_f, 1'b0, 24'h0);
    chk_cmd_frame("f11", 16'hE000, 20'h15000, 20'h55550);
    chk("f11_pend", 256'(cmd_pending), 256'(0));
    chk("rd_hold",  256'({rd_addr, rd_data}), 256'({7'h7C, 16'h4E53}));

    // Reset mid-frame at cnt 100 with two commands queued.
    push_cmd(1'b0, 7'h20, 16'hAAAA);
    push_cmd(1'b0, 7'h21, 16'hBBBB);
    chk("mid_pend2", 256'(cmd_pending), 256'(2));
    repeat (98) @(negedge bit_clk);
    reset_b = 1'b0;
    #1;
    chk("mid_rst_out", 256'({sync, sdata_out, frame_start, rd_valid, codec_ready, rd_addr, rd_data}), 256'(0));
    chk("mid_rst_pend", 256'(cmd_pending), 256'(0));
    @(negedge bit_clk);
    reset_b = 1'b1;
    wait_fs("post_rst_start");
    capture_frame(zero_f, 1'b0, 24'h0);
    chk("post_rst_frame",   cap_f, 256'(0));
    chk("post_rst_sync_hi", 256'(sync_hi), 256'(16));
    chk("post_rst_pend",    256'(cmd_pending), 256'(0));

    // Enable dropped at cnt 0: this frame completes, then the link goes quiet.
    enable = 1'b0;
    sh  = 0;
    fsn = 0;
    for (int i = 0; i < 400; i++) begin
      if (sync === 1'b1) sh++;
      if (i > 0 && frame_start === 1'b1) fsn++;
      @(negedge bit_clk);
    end
    chk("drop_sync_hi", 256'(sh), 256'(16));
    chk("drop_fs",      256'(fsn), 256'(0));
    chk("drop_idle",    256'({sync, sdata_out}), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
